// File: rtl/watchdog_multi.sv
// ============================================================================
// watchdog_multi : NCH windowed watchdog channels, shared prescaler,
//                  key-protected configuration, stretchable reset pulse.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module watchdog_multi #(
    parameter int         NCH        = 4,
    parameter int         PRESC      = 16,
    parameter logic [7:0] KEY        = 8'hA5,
    parameter logic [7:0] RSTLEN_DEF = 8'd32
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_wr,
    input  logic [2:0]     i_abus,
    input  logic [7:0]     i_dbus,
    output logic           o_rstout,
    output logic [NCH-1:0] o_fail,
    output logic [NCH-1:0] o_cause
);

    localparam logic [2:0]  c_A_KEY     = 3'd0;
    localparam logic [2:0]  c_A_CHSEL   = 3'd1;
    localparam logic [2:0]  c_A_WOPEN   = 3'd2;
    localparam logic [2:0]  c_A_WCLOSE  = 3'd3;
    localparam logic [2:0]  c_A_CTRL    = 3'd4;
    localparam logic [2:0]  c_A_SERVICE = 3'd5;
    localparam logic [2:0]  c_A_RSTLEN  = 3'd6;
    localparam logic [2:0]  c_A_FCLR    = 3'd7;
    localparam logic [15:0] c_PRESC_MAX = 16'(PRESC - 1);

    logic           r_unlock;
    logic [2:0]     r_chsel;
    logic [7:0]     r_rstlen;
    logic [15:0]    r_presc;
    logic           r_pend;
    logic [7:0]     r_pulse;
    logic           r_rstout;
    logic           w_tick;
    logic           w_cfg;
    logic [7:0]     w_pulse_nxt;
    logic [NCH-1:0] w_failev;

    assign w_tick = (r_presc == c_PRESC_MAX);
    assign w_cfg  = i_wr && r_unlock;

    // The pulse is loaded one cycle after the failure event so RSTOUT trails FAIL.
    always_comb begin
        w_pulse_nxt = r_pulse;
        if (r_pend) begin
            w_pulse_nxt = (r_rstlen == 8'd0) ? 8'd1 : r_rstlen;
        end else if (r_pulse != 8'd0) begin
            w_pulse_nxt = r_pulse - 8'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_unlock <= 1'b0;
            r_chsel  <= 3'd0;
            r_rstlen <= RSTLEN_DEF;
            r_presc  <= 16'd0;
            r_pend   <= 1'b0;
            r_pulse  <= 8'd0;
            r_rstout <= 1'b0;
        end else begin
            r_presc <= w_tick ? 16'd0 : r_presc + 16'd1;
            if (i_wr) begin
                r_unlock <= (i_abus == c_A_KEY) && (i_dbus == KEY);
            end
            if (w_cfg && (i_abus == c_A_CHSEL)) begin
                r_chsel <= i_dbus[2:0];
            end
            if (w_cfg && (i_abus == c_A_RSTLEN)) begin
                r_rstlen <= i_dbus;
            end
            r_pend   <= |w_failev;
            r_pulse  <= w_pulse_nxt;
            r_rstout <= (w_pulse_nxt != 8'd0);
        end
    end

    assign o_rstout = r_rstout;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic       r_en;
        logic       r_fail;
        logic       r_cause;
        logic [7:0] r_cnt;
        logic [7:0] r_wopen;
        logic [7:0] r_wclose;
        logic       w_sel;
        logic       w_svc;
        logic       w_early;
        logic       w_good;
        logic       w_tmo;
        logic       w_ctrl;
        logic       w_en_nxt;
        logic       w_start;

        assign w_sel    = w_cfg && (r_chsel == 3'(gi));
        assign w_svc    = i_wr && (i_abus == c_A_SERVICE) && (i_dbus[2:0] == 3'(gi));
        assign w_early  = r_en && w_svc && (r_cnt < r_wopen);
        assign w_good   = r_en && w_svc && !w_early && (r_cnt <= r_wclose);
        // A WCLOSE of 255 disables timeout because the counter saturates there.
        assign w_tmo    = r_en && w_tick && !w_early && !w_good &&
                          (r_wclose != 8'hFF) && (r_cnt >= r_wclose);
        assign w_ctrl   = w_sel && (i_abus == c_A_CTRL);
        assign w_en_nxt = w_ctrl ? i_dbus[0] : r_en;
        assign w_start  = w_ctrl && i_dbus[0] && !r_en;

        assign w_failev[gi] = w_early || w_tmo;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_en     <= 1'b0;
                r_fail   <= 1'b0;
                r_cause  <= 1'b0;
                r_cnt    <= 8'd0;
                r_wopen  <= 8'd0;
                r_wclose <= 8'hFF;
            end else begin
                if (w_sel && (i_abus == c_A_WOPEN)) begin
                    r_wopen <= i_dbus;
                end
                if (w_sel && (i_abus == c_A_WCLOSE)) begin
                    r_wclose <= i_dbus;
                end
                if (w_failev[gi]) begin
                    r_en   <= 1'b0;
                    r_cnt  <= 8'd0;
                    r_fail <= 1'b1;
                    if (!r_fail) begin
                        r_cause <= w_early;
                    end
                end else begin
                    r_en <= w_en_nxt;
                    if (!w_en_nxt || w_start || w_good) begin
                        r_cnt <= 8'd0;
                    end else if (w_tick && (r_cnt != 8'hFF)) begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                    if (w_cfg && (i_abus == c_A_FCLR) && i_dbus[gi]) begin
                        r_fail <= 1'b0;
                    end
                end
            end
        end

        assign o_fail[gi]  = r_fail;
        assign o_cause[gi] = r_cause;
    end

endmodule

`default_nettype wire

// File: tb/tb_watchdog_multi.sv
// ============================================================================
// tb_watchdog_multi : randomized + directed scoreboard bench for watchdog_multi.
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_watchdog_multi;

    localparam int         NCH   = 4;
    localparam int         PRESC = 3;
    localparam logic [7:0] KEY   = 8'hA5;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b1;
    logic           wr    = 1'b0;
    logic [2:0]     abus  = 3'd0;
    logic [7:0]     dbus  = 8'd0;
    logic           rstout;
    logic [NCH-1:0] fail;
    logic [NCH-1:0] cause;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    watchdog_multi #(
        .NCH(NCH), .PRESC(PRESC), .KEY(KEY), .RSTLEN_DEF(8'd32)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_wr(wr), .i_abus(abus), .i_dbus(dbus),
        .o_rstout(rstout), .o_fail(fail), .o_cause(cause)
    );

    typedef struct packed {
        logic           r;
        logic [NCH-1:0] f;
        logic [NCH-1:0] c;
    } exp_t;

    exp_t sbq[$];

    // Reference model state: what the watchdog should hold after each clock edge.
    int unsigned m_k;
    bit          m_unlock;
    int          m_chsel;
    bit          m_en   [NCH];
    int          m_cnt  [NCH];
    int          m_wo   [NCH];
    int          m_wc   [NCH];
    bit          m_fail [NCH];
    bit          m_cause[NCH];
    int          m_rstlen;
    bit          m_pend;
    int          m_left;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_k = 0; m_unlock = 0; m_chsel = 0; m_rstlen = 32; m_pend = 0; m_left = 0;
        for (int ch = 0; ch < NCH; ch++) begin
            m_en[ch] = 0; m_cnt[ch] = 0; m_wo[ch] = 0; m_wc[ch] = 255;
            m_fail[ch] = 0; m_cause[ch] = 0;
        end
    endtask

    task automatic model_step(input logic w, input logic [2:0] a, input logic [7:0] d);
        bit tick, any, cfg, early, good, ev, justen;
        tick = ((m_k % PRESC) == PRESC - 1);
        m_k++;
        cfg = w && m_unlock;
        any = 0;
        if (m_pend) m_left = (m_rstlen == 0) ? 1 : m_rstlen;
        else if (m_left > 0) m_left--;
        for (int ch = 0; ch < NCH; ch++) begin
            early = 0; good = 0; ev = 0; justen = 0;
            if (m_en[ch]) begin
                if (w && a == 3'd5 && int'(d[2:0]) == ch) begin
                    if (m_cnt[ch] < m_wo[ch]) early = 1;
                    else if (m_cnt[ch] <= m_wc[ch]) good = 1;
                end
                if (!early && !good && tick && m_wc[ch] != 255 && m_cnt[ch] >= m_wc[ch]) ev = 1;
            end
            ev = ev || early;
            if (cfg && m_chsel == ch && a == 3'd2) m_wo[ch] = int'(d);
            if (cfg && m_chsel == ch && a == 3'd3) m_wc[ch] = int'(d);
            if (ev) begin
                any = 1;
                if (!m_fail[ch]) m_cause[ch] = early;
                m_fail[ch] = 1; m_en[ch] = 0; m_cnt[ch] = 0;
            end else begin
                if (cfg && m_chsel == ch && a == 3'd4) begin
                    justen = d[0] && !m_en[ch];
                    m_en[ch] = d[0];
                end
                if (!m_en[ch] || justen || good) m_cnt[ch] = 0;
                else if (tick && m_cnt[ch] < 255) m_cnt[ch]++;
                if (cfg && a == 3'd7 && d[ch]) m_fail[ch] = 0;
            end
        end
        m_pend = any;
        if (cfg && a == 3'd1) m_chsel = int'(d[2:0]);
        if (cfg && a == 3'd6) m_rstlen = int'(d);
        if (w) m_unlock = (a == 3'd0 && d == KEY);
    endtask

    // Called at a falling edge: applies one cycle of stimulus and queues the expectation.
    task automatic cyc(input logic w, input logic [2:0] a, input logic [7:0] d);
        exp_t e;
        wr = w; abus = a; dbus = d;
        model_step(w, a, d);
        e.r = (m_left != 0);
        for (int ch = 0; ch < NCH; ch++) begin
            e.f[ch] = m_fail[ch];
            e.c[ch] = m_cause[ch];
        end
        sbq.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 3'd0, 8'd0);
    endtask

    task automatic kw(input logic [2:0] a, input logic [7:0] d);
        cyc(1'b1, 3'd0, KEY);
        cyc(1'b1, a, d);
    endtask

    task automatic config_ch(input int ch, input int wo, input int wc, input bit en);
        kw(3'd1, 8'(ch));
        kw(3'd2, 8'(wo));
        kw(3'd3, 8'(wc));
        kw(3'd4, {7'd0, en});
    endtask

    task automatic do_reset(input string nm);
        #2 rst_n = 1'b0;
        wr = 1'b0; abus = 3'd0; dbus = 8'd0;
        #1;
        chk({nm, "_rstout"}, {31'd0, rstout}, 32'd0);
        chk({nm, "_fail"}, {28'd0, fail}, 32'd0);
        chk({nm, "_cause"}, {28'd0, cause}, 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: one expectation per clock, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                checks++;
                if ({rstout, fail, cause} !== e) begin
                    errors++;
                    $display("FAIL scoreboard actual r=%0b f=%b c=%b expected r=%0b f=%b c=%b at %0t",
                             rstout, fail, cause, e.r, e.f, e.c, $time);
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int n;
        bit seen;
        do_reset("reset0");

        // Locked WCLOSE write is ignored, so the enabled channel never times out.
        cyc(1'b1, 3'd3, 8'd3);
        kw(3'd4, 8'd1);
        idle(40);
        chk("locked_wclose_nofail", {28'd0, fail}, 32'd0);
        kw(3'd3, 8'd3);
        for (n = 0; n < 200; n++) begin
            idle(1);
            if (fail[0]) break;
        end
        chk("unlocked_wclose_timeout", {31'd0, fail[0]}, 32'd1);

        do_reset("reset1");
        config_ch(0, 2, 5, 1'b1);
        for (n = 0; n < 200; n++) begin
            idle(1);
            if (fail[0]) break;
        end
        chk("timeout_fail0", {31'd0, fail[0]}, 32'd1);
        chk("timeout_cause0", {31'd0, cause[0]}, 32'd0);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            idle(1);
            if (rstout) n++;
            else if (n > 0) break;
        end
        chk("timeout_pulse_len", n, 32);

        do_reset("reset2");
        config_ch(1, 200, 250, 1'b1);
        cyc(1'b1, 3'd5, 8'd1);
        chk("early_fail1", {31'd0, fail[1]}, 32'd1);
        chk("early_cause1", {31'd0, cause[1]}, 32'd1);
        idle(3);
        chk("midpulse_rstout", {31'd0, rstout}, 32'd1);
        do_reset("async_midpulse");

        config_ch(0, 2, 5, 1'b1);
        seen = 0;
        for (int s = 0; s < 100; s++) begin
            for (n = 0; n < 40 && m_cnt[0] != 3; n++) begin
                idle(1);
                seen |= rstout;
            end
            if (n == 40) chk("good_wait_bound", n, 0);
            cyc(1'b1, 3'd5, 8'd0);
            seen |= rstout;
        end
        chk("good_service_fail", {28'd0, fail}, 32'd0);
        chk("good_service_rstout", {31'd0, seen}, 32'd0);

        do_reset("reset3");
        config_ch(0, 200, 250, 1'b1);
        config_ch(2, 200, 250, 1'b1);
        kw(3'd6, 8'd20);
        cyc(1'b1, 3'd5, 8'd0);
        n = 0;
        for (int i = 0; i < 9; i++) begin
            idle(1);
            if (rstout) n++;
        end
        cyc(1'b1, 3'd5, 8'd2);
        if (rstout) n++;
        for (int i = 0; i < 100; i++) begin
            idle(1);
            if (rstout) n++;
            else break;
        end
        chk("overlap_pulse_len", n, 30);
        chk("overlap_fail", {28'd0, fail}, 32'h5);
        kw(3'd7, 8'h05);
        chk("fclr_fail", {28'd0, fail}, 32'd0);

        do_reset("reset4");
        for (int op = 0; op < 400; op++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: config_ch($urandom_range(0, 4), $urandom_range(0, 6),
                                   ($urandom_range(0, 7) == 0) ? 255 : $urandom_range(2, 10),
                                   ($urandom_range(0, 3) != 0));
                3, 4, 5: begin
                    cyc(1'b1, 3'd5, 8'($urandom_range(0, 7)));
                    idle($urandom_range(0, 6));
                end
                6: kw(3'd7, 8'($urandom_range(0, 15)));
                7: kw(3'd6, 8'($urandom_range(0, 12)));
                8: cyc(1'b1, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
                default: idle($urandom_range(1, 15));
            endcase
        end
        idle(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
